// File: rtl/mem_access_ctrl.sv
// Multicycle load/store controller for a word-wide unified memory.
// Sub-word stores are done as read-modify-write; loads return an aligned, extended result.
module mem_access_ctrl #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        addr_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [3:0] LAST    = 4'(READ_LATENCY);

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        we_q, sign_q, err_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q, word_q;

   logic        req_err;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_val, merged;

   // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      req_err   = (size == 2'b11) ||
                  (size == SZ_HALF && addr[0]) ||
                  (size == SZ_WORD && addr[1:0] != 2'b00);

      lane_b   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_h   = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      load_val = mem_rdata;
      if (size_q == SZ_BYTE)
         load_val = {{24{sign_q & lane_b[7]}}, lane_b};
      else if (size_q == SZ_HALF)
         load_val = {{16{sign_q & lane_h[15]}}, lane_h};

      // Read-modify-write: only the target lane of the captured word is replaced.
      merged = word_q;
      if (size_q == SZ_BYTE)
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else if (size_q == SZ_HALF)
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      else
         merged = wdata_q;

      case (state)
         IDLE: begin
            if (start) begin
               if (req_err)
                  state_nxt = DONE;
               else if (we && size == SZ_WORD)
                  state_nxt = WRITE;
               else
                  state_nxt = READ;
            end
         end
         READ:  if (cnt == LAST) state_nxt = we_q ? WRITE : DONE;
         WRITE: state_nxt = DONE;
         DONE:  state_nxt = IDLE;
      endcase

      busy      = (state != IDLE);
      done      = (state == DONE);
      addr_err  = (state == DONE) && err_q;
      mem_we    = (state == WRITE);
      mem_addr  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
      mem_wdata = mem_we ? merged : 32'h0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         rdata   <= 32'h0;
         we_q    <= 1'b0;
         sign_q  <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         word_q  <= 32'h0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            we_q    <= we;
            size_q  <= size;
            sign_q  <= sign;
            addr_q  <= addr;
            wdata_q <= wdata;
            err_q   <= req_err;
            cnt     <= 4'd0;
         end
         if (state == READ) begin
            cnt <= (cnt == LAST) ? 4'd0 : cnt + 4'd1;
            // Last read cycle: mem_rdata is valid now.
            if (cnt == LAST) begin
               if (we_q)
                  word_q <= mem_rdata;
               else
                  rdata <= load_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: two controllers (READ_LATENCY 1 and 3) driven with identical requests,
// each with its own latency-modelled memory, compared against a shift/mask reference model.
module tb_mem_access_ctrl;

   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   logic        clk = 1'b0;
   logic        reset, start, we, sign;
   logic [1:0]  size;
   logic [31:0] addr, wdata;

   logic [31:0] rdata_o[2], mem_addr_o[2], mem_wdata_o[2], mem_rdata_i[2];
   logic        busy_o[2], done_o[2], err_o[2], mem_we_o[2];

   logic        pl_en;
   logic [5:0]  pl_idx;
   logic [31:0] pl_data;
   logic [31:0] mem [2][64];
   logic [31:0] pipe[2][4];

   logic [31:0] model_mem[64];
   logic [31:0] exp_rdata;
   int          total, bad;

   always #5 clk = ~clk;

   mem_access_ctrl #(.READ_LATENCY(LAT0)) dut_l1 (
      .clk(clk), .reset(reset), .start(start), .we(we), .size(size), .sign(sign),
      .addr(addr), .wdata(wdata), .rdata(rdata_o[0]), .busy(busy_o[0]), .done(done_o[0]),
      .addr_err(err_o[0]), .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]),
      .mem_we(mem_we_o[0]), .mem_rdata(mem_rdata_i[0]));

   mem_access_ctrl #(.READ_LATENCY(LAT1)) dut_l3 (
      .clk(clk), .reset(reset), .start(start), .we(we), .size(size), .sign(sign),
      .addr(addr), .wdata(wdata), .rdata(rdata_o[1]), .busy(busy_o[1]), .done(done_o[1]),
      .addr_err(err_o[1]), .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]),
      .mem_we(mem_we_o[1]), .mem_rdata(mem_rdata_i[1]));

   // Memory: read data emerges LAT cycles after the address, writes land on the edge.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         pipe[i][0] <= mem[i][mem_addr_o[i][7:2]];
         for (int j = 1; j < 4; j++) pipe[i][j] <= pipe[i][j-1];
         if (pl_en)
            mem[i][pl_idx] <= pl_data;
         else if (mem_we_o[i])
            mem[i][mem_addr_o[i][7:2]] <= mem_wdata_o[i];
      end
   end
   assign mem_rdata_i[0] = pipe[0][LAT0-1];
   assign mem_rdata_i[1] = pipe[1][LAT1-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                              input logic sg, input logic [1:0] off);
      logic [31:0] v;
      v = word;
      if (sz == 2'd0) begin
         v = (word >> (8 * off)) & 32'hFF;
         if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (word >> (8 * off)) & 32'hFFFF;
         if (sg && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] off, input logic [31:0] d);
      logic [31:0] mask;
      mask = (sz == 2'd0) ? (32'hFF << (8 * off)) :
             (sz == 2'd1) ? (32'hFFFF << (8 * off)) : 32'hFFFF_FFFF;
      return (word & ~mask) | ((d << (8 * off)) & mask);
   endfunction

   function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
   endfunction

   task automatic run_op(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] d, input logic hold, input logic wait_first,
                         input string name);
      int          lat[2], exp_done[2], exp_we[2];
      int          done_cyc[2], done_cnt[2], we_cyc[2], we_cnt[2], idle_cyc[2];
      logic [31:0] we_addr[2], we_data[2];
      logic        err_seen[2];
      logic [31:0] exp_wd, word_a;
      logic [5:0]  widx;
      logic        e;

      lat    = '{LAT0, LAT1};
      e      = model_err(sz, a);
      word_a = {a[31:2], 2'b00};
      widx   = a[7:2];
      exp_wd = (e || !w) ? 32'h0 : model_store(model_mem[widx], sz, a[1:0], d);
      for (int i = 0; i < 2; i++) begin
         if (e)              begin exp_done[i] = 1;          exp_we[i] = 0;          end
         else if (!w)        begin exp_done[i] = lat[i] + 2; exp_we[i] = 0;          end
         else if (sz == 2'd2) begin exp_done[i] = 2;         exp_we[i] = 1;          end
         else                begin exp_done[i] = lat[i] + 3; exp_we[i] = lat[i] + 2; end
         done_cyc[i] = 0; done_cnt[i] = 0; we_cyc[i] = 0; we_cnt[i] = 0; idle_cyc[i] = 0;
         we_addr[i] = 32'h0; we_data[i] = 32'h0; err_seen[i] = 1'b0;
      end

      if (wait_first) @(negedge clk);
      we = w; size = sz; sign = sg; addr = a; wdata = d; start = 1'b1;

      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (k == 1) check($sformatf("%s/L%0d/maddr", name, lat[i]), mem_addr_o[i], word_a);
            if (done_o[i]) begin
               done_cnt[i]++;
               if (done_cyc[i] == 0) done_cyc[i] = k;
               err_seen[i] = err_o[i];
            end
            if (mem_we_o[i]) begin
               we_cnt[i]++;
               we_cyc[i]  = k;
               we_addr[i] = mem_addr_o[i];
               we_data[i] = mem_wdata_o[i];
            end
            if (!busy_o[i] && idle_cyc[i] == 0) idle_cyc[i] = k;
         end
         // Latched request must not depend on inputs after acceptance.
         if (k == 1) begin
            addr = $urandom; wdata = $urandom; size = 2'($urandom_range(3));
            we = 1'($urandom); sign = 1'($urandom);
         end
         start = hold && (k <= exp_done[0]);
      end

      if (!e && w) model_mem[widx] = exp_wd;
      if (!e && !w) exp_rdata = model_load(model_mem[widx], sz, sg, a[1:0]);

      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s/L%0d/done_cyc", name, lat[i]), done_cyc[i], exp_done[i]);
         check($sformatf("%s/L%0d/done_cnt", name, lat[i]), done_cnt[i], 1);
         check($sformatf("%s/L%0d/addr_err", name, lat[i]), {31'h0, err_seen[i]}, {31'h0, e});
         check($sformatf("%s/L%0d/idle_cyc", name, lat[i]), idle_cyc[i], exp_done[i] + 1);
         check($sformatf("%s/L%0d/we_cnt", name, lat[i]), we_cnt[i], (exp_we[i] > 0) ? 1 : 0);
         if (exp_we[i] > 0) begin
            check($sformatf("%s/L%0d/we_cyc", name, lat[i]), we_cyc[i], exp_we[i]);
            check($sformatf("%s/L%0d/we_addr", name, lat[i]), we_addr[i], word_a);
            check($sformatf("%s/L%0d/we_data", name, lat[i]), we_data[i], exp_wd);
         end
         check($sformatf("%s/L%0d/rdata", name, lat[i]), rdata_o[i], exp_rdata);
         check($sformatf("%s/L%0d/idle_maddr", name, lat[i]), mem_addr_o[i], 32'h0);
      end
   endtask

   initial begin
      int rst_we;
      total = 0; bad = 0; exp_rdata = 32'h0;
      reset = 1'b1; start = 1'b0; we = 1'b0; size = 2'b00; sign = 1'b0;
      addr = 32'h0; wdata = 32'h0; pl_en = 1'b0; pl_idx = 6'd0; pl_data = 32'h0;

      for (int w = 0; w < 64; w++) begin
         @(negedge clk);
         pl_en   = 1'b1;
         pl_idx  = 6'(w);
         pl_data = (w == 4) ? 32'h8899_AABB : $urandom;
         model_mem[w] = pl_data;
      end
      @(negedge clk);
      pl_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset/%0d/ctl", i),
               {28'h0, busy_o[i], done_o[i], err_o[i], mem_we_o[i]}, 32'h0);
         check($sformatf("reset/%0d/maddr", i), mem_addr_o[i], 32'h0);
         check($sformatf("reset/%0d/mwdata", i), mem_wdata_o[i], 32'h0);
         check($sformatf("reset/%0d/rdata", i), rdata_o[i], 32'h0);
      end
      reset = 1'b0;

      // Loads from word 0x10 = 0x8899AABB
      run_op(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0, 1'b1, "lb_s");
      check("lb_s/const", rdata_o[0], 32'hFFFF_FFAA);
      run_op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0, 1'b1, "lb_u");
      check("lb_u/const", rdata_o[1], 32'h0000_00AA);
      run_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, 1'b1, "lh_s");
      check("lh_s/const", rdata_o[0], 32'hFFFF_8899);
      run_op(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, "lh_u");
      check("lh_u/const", rdata_o[1], 32'h0000_AABB);

      // Read-modify-write byte store, then read back
      run_op(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0012, 1'b0, 1'b1, "sb");
      run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, "lw");
      check("lw/const", rdata_o[0], 32'h1299_AABB);
      run_op(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, 1'b0, 1'b1, "sw");

      // Errors with start held through busy
      run_op(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1'b1, 1'b1, "err_lw");
      run_op(1'b1, 2'd1, 1'b0, 32'h21, 32'h5555_AAAA, 1'b1, 1'b1, "err_sh");
      run_op(1'b1, 2'd3, 1'b0, 32'h00, 32'h1234_5678, 1'b1, 1'b1, "err_rsv");
      run_op(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000_CAFE, 1'b1, 1'b1, "sh_hold");

      // Reset during READ aborts the access without a write
      rst_we = 0;
      @(negedge clk);
      we = 1'b1; size = 2'd1; sign = 1'b0; addr = 32'h30; wdata = 32'h0000_BEEF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) if (mem_we_o[i]) rst_we++;
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (mem_we_o[i]) rst_we++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_rdata = 32'h0;
      check("rst_mid/we_seen", rst_we, 0);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst_mid/%0d/ctl", i),
               {28'h0, busy_o[i], done_o[i], err_o[i], mem_we_o[i]}, 32'h0);
         check($sformatf("rst_mid/%0d/maddr", i), mem_addr_o[i], 32'h0);
         check($sformatf("rst_mid/%0d/mwdata", i), mem_wdata_o[i], 32'h0);
         check($sformatf("rst_mid/%0d/rdata", i), rdata_o[i], 32'h0);
      end
      run_op(1'b0, 2'd1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, "after_rst");

      // Randomized mix against the reference model
      for (int n = 0; n < 40; n++) begin
         logic [31:0] ra;
         ra = {24'h0, 6'($urandom_range(15)), 2'($urandom_range(3))};
         run_op(1'($urandom), 2'($urandom_range(3)), 1'($urandom), ra, $urandom,
                1'($urandom), 1'b1, $sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multicycle memory access controller sitting directly downstream of the instruction/data address multiplexer. It takes the selected 32-bit byte address and a load/store request from the control unit. It performs word, halfword or byte accesses against the word-wide unified memory, using read-modify-write for sub-word stores. It returns an aligned, extended load result to the memory data register path.

## Interface
- READ_LATENCY, 1: cycles from mem_addr presented to mem_rdata valid; legal range 1–15.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; forces IDLE.
- start  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address from the address mux.
- wdata  in  32  store data, right-justified.
- rdata  out  32  load result, extended; held until the next completed load.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- addr_err  out  1  valid with done; misaligned address or reserved size.
- mem_addr  out  32  word address {addr_q[31:2],2'b00}.
- mem_wdata  out  32  word to write.
- mem_we  out  1  memory write enable, one cycle per store.
- mem_rdata  in  32  memory read data.

## Operation
- Little-endian lanes: offset addr[1:0]=k selects byte bits 8k+7:8k. Halfword at offset 0 uses bits 15:0; at offset 2 it uses bits 31:16.
- In IDLE, start=1 latches we, size, sign, addr and wdata into internal registers. Later changes on these inputs have no effect.
- Alignment rules:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - size=11 is always an error.
  - On error, go to DONE with addr_err=1. No memory read and no mem_we.
- States and transitions:
  - IDLE.
  - READ: counter runs 0..READ_LATENCY.
  - WRITE: one cycle.
  - DONE: one cycle, then IDLE.
- Load: IDLE→READ→DONE. On the last READ cycle, capture the selected lane from mem_rdata, extended per sign, into rdata.
- Store word: IDLE→WRITE→DONE. mem_wdata=wdata_q.
- Store byte/half: IDLE→READ→WRITE→DONE. The last READ cycle captures mem_rdata. In WRITE, mem_wdata is the captured word with the target lane replaced by wdata_q[7:0] or wdata_q[15:0]. All other bits are unchanged.
- mem_we=1 only in WRITE. mem_addr is driven from the latched address whenever busy, and is 0 in IDLE.
- start is ignored while busy, including in DONE. There is no queueing.
- rdata changes only on a successful load capture. Stores and errors leave it untouched.

## Timing
- Let T be the IDLE cycle in which start=1.
- Reset: all outputs 0, rdata=0, state IDLE, counter 0. Reset takes effect at the next edge from any state.
- Reset asserted during READ or WRITE aborts the access. If reset is sampled in the WRITE cycle, the mem_we of that cycle is still visible combinationally. The verification bench must treat the memory contents after such a reset as undefined.
- Error cases: busy=1 and done=1 and addr_err=1 in T+1. IDLE in T+2.
- Load: mem_addr presented in T+1. mem_rdata is valid in T+1+L, with L=READ_LATENCY, and is captured at the end of that cycle. done and the new rdata appear in T+2+L. Total latency is L+2.
- Store word: mem_we=1 in T+1. done in T+2.
- Store byte/half: READ from T+1 to T+1+L. mem_we=1 in T+2+L. done in T+3+L.
- The earliest accepted back-to-back start is the cycle after DONE.

## Test plan
- LB, L=1: memory[0x10]=0x8899AABB. LB signed at addr 0x11, start at T → rdata=0xFFFFFFAA with done in T+3. LBU at the same address → rdata=0x000000AA.
- LH signed at addr 0x12, same word → rdata=0xFFFF8899. LH unsigned at addr 0x10 → rdata=0x0000AABB. addr_err=0 in both cases.
- SB wdata=0x00000012 at addr 0x13, L=1:
  - mem_we is seen only in T+3, with mem_addr=0x10 and mem_wdata=0x1299AABB.
  - done in T+4.
  - A subsequent LW at 0x10 returns 0x1299AABB.
- SW wdata=0xDEADBEEF at addr 0x20 → mem_we in T+1, done in T+2, rdata unchanged. Repeat with READ_LATENCY=3 → same 2-cycle timing.
- Misaligned and reserved requests:
  - LW at 0x12, SH at 0x21, and size=11 at 0x00 each give done=addr_err=1 in T+1.
  - mem_we is never asserted and rdata is unchanged.
  - start pulses held during busy are ignored: exactly one done per accepted request.
- Reset mid-access: SH at 0x30 with L=3, reset asserted in T+2 (READ) → mem_we never asserted. All outputs are 0 from T+3, and a new start in T+3 is accepted normally.
